// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry hold register, 31x32 register file, priority bypass.
// Define DEC_SCOREBOARD_EN to add the per-register load-use scoreboard.
module decode_stage #(
  parameter int unsigned FWD_PORTS = 2,
  parameter int unsigned LOAD_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_inst,
  input  logic                   flush,
  input  logic [FWD_PORTS-1:0]   fwd_valid,
  input  logic [5*FWD_PORTS-1:0] fwd_rd,
  input  logic [32*FWD_PORTS-1:0] fwd_data,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [2:0]             out_class,
  output logic [3:0]             out_alu_op,
  output logic [2:0]             out_funct3,
  output logic [4:0]             out_rd,
  output logic                   out_rd_we,
  output logic [31:0]            out_src1,
  output logic [31:0]            out_src2,
  output logic [31:0]            out_imm,
  output logic                   out_illegal
);

  typedef enum logic [2:0] {
    CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_UPPER
  } class_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } alu_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_lat
    $error("decode_stage: LOAD_LAT must be 1..7");
  end

  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        out_fire;
  logic        hazard;
  logic [31:0] regs [1:31];

  assign out_fire  = out_valid && out_ready;
  assign in_ready  = !flush && (!hold_valid || out_fire);
  assign out_valid = hold_valid && !hazard && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_inst  <= 32'h0000_0013;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold_valid <= 1'b1;
      hold_pc    <= in_pc;
      hold_inst  <= in_inst;
    end else if (out_fire) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned r = 1; r < 32; r++) regs[r[4:0]] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

  assign opc    = hold_inst[6:0];
  assign f3     = hold_inst[14:12];
  assign f7     = hold_inst[31:25];
  assign rd     = hold_inst[11:7];
  assign rs1    = hold_inst[19:15];
  assign rs2    = hold_inst[24:20];
  assign imm_i  = {{20{hold_inst[31]}}, hold_inst[31:20]};
  assign imm_s  = {{20{hold_inst[31]}}, hold_inst[31:25], hold_inst[11:7]};
  assign imm_b  = {{19{hold_inst[31]}}, hold_inst[31], hold_inst[7], hold_inst[30:25],
                   hold_inst[11:8], 1'b0};
  assign imm_j  = {{11{hold_inst[31]}}, hold_inst[31], hold_inst[19:12], hold_inst[20],
                   hold_inst[30:21], 1'b0};
  assign imm_u  = {hold_inst[31:12], 12'b0};
  assign imm_sh = {27'b0, hold_inst[24:20]};

  function automatic alu_e f3_op(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  class_e      dec_class;
  alu_e        dec_op;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic        use_rs1, use_rs2;

  always_comb begin
    dec_class   = CL_ALU_I;
    dec_op      = OP_ADD;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opc)
      OPC_OP: begin
        dec_class = CL_ALU_R;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_op    = f3_op(f3, hold_inst[30]);
        dec_illegal = !(f7 == 7'b0000000 ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        dec_op  = f3_op(f3, (f3 == 3'b101) && hold_inst[30]);
        dec_imm = imm_i;
        // shifts present the bare shamt rather than the funct7-polluted I-immediate
        if (f3 == 3'b001) begin
          dec_imm     = imm_sh;
          dec_illegal = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec_imm     = imm_sh;
          dec_illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
        end
      end
      OPC_LOAD: begin
        dec_class   = CL_LOAD;
        use_rs1     = 1'b1;
        dec_imm     = imm_i;
        dec_illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OPC_STORE: begin
        dec_class   = CL_STORE;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec_imm     = imm_s;
        dec_illegal = (f3[2] || f3 == 3'b011);
      end
      OPC_BRANCH: begin
        dec_class   = CL_BRANCH;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec_imm     = imm_b;
        dec_illegal = (f3 == 3'b010 || f3 == 3'b011);
      end
      OPC_JAL: begin
        dec_class = CL_JAL;
        dec_imm   = imm_j;
      end
      OPC_JALR: begin
        dec_class   = CL_JALR;
        use_rs1     = 1'b1;
        dec_imm     = imm_i;
        dec_illegal = (f3 != 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_class = CL_UPPER;
        dec_imm   = imm_u;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf_val);
    logic [31:0] v;
    logic        hit;
    v   = rf_val;
    hit = 1'b0;
    for (int unsigned i = 0; i < FWD_PORTS; i++) begin
      if (!hit && fwd_valid[i] && fwd_rd[5*i +: 5] == rs) begin
        v   = fwd_data[32*i +: 32];
        hit = 1'b1;
      end
    end
    if (!hit && wb_we && wb_rd == rs) v = wb_data;
    if (rs == 5'd0) v = '0;
    return v;
  endfunction

  logic [31:0] rf1, rf2, op_a, op_b;

  always_comb begin
    rf1  = (rs1 == 5'd0) ? '0 : regs[rs1];
    rf2  = (rs2 == 5'd0) ? '0 : regs[rs2];
    op_a = resolve(rs1, rf1);
    op_b = resolve(rs2, rf2);
  end

`ifdef DEC_SCOREBOARD_EN
  logic [2:0] pending [1:31];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned r = 1; r < 32; r++) pending[r[4:0]] <= '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (out_fire && dec_class == CL_LOAD && rd == r[4:0])
          pending[r[4:0]] <= 3'(LOAD_LAT);
        else if (pending[r[4:0]] != 3'd0)
          pending[r[4:0]] <= pending[r[4:0]] - 3'd1;
      end
    end
  end

  assign hazard = (use_rs1 && rs1 != 5'd0 && pending[rs1] != 3'd0) ||
                  (use_rs2 && rs2 != 5'd0 && pending[rs2] != 3'd0);
`else
  logic unused_dec;
  assign unused_dec = use_rs1 ^ use_rs2;
  assign hazard     = 1'b0;
`endif

  assign out_pc      = hold_pc;
  assign out_class   = dec_class;
  assign out_alu_op  = dec_op;
  assign out_funct3  = f3;
  assign out_rd      = rd;
  assign out_rd_we   = (rd != 5'd0) && !dec_illegal &&
                       dec_class != CL_STORE && dec_class != CL_BRANCH;
  assign out_src1    = (dec_class == CL_UPPER) ? ((opc == OPC_AUIPC) ? hold_pc : '0) : op_a;
  assign out_src2    = op_b;
  assign out_imm     = dec_imm;
  assign out_illegal = dec_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (FWD_PORTS=2, LOAD_LAT=2).
module tb_decode_stage;
  localparam int unsigned FWD_PORTS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        flush;
  logic [FWD_PORTS-1:0]    fwd_valid;
  logic [5*FWD_PORTS-1:0]  fwd_rd;
  logic [32*FWD_PORTS-1:0] fwd_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [2:0]  out_class;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_src1, out_src2, out_imm;
  logic        out_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.FWD_PORTS(FWD_PORTS), .LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_class(out_class), .out_alu_op(out_alu_op), .out_funct3(out_funct3),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_src1(out_src1),
    .out_src2(out_src2), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    step();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    step(); step();
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_ready",   32'(in_ready), 32'd1);
    check("rst_class",   32'(out_class), 32'd1);
    check("rst_aluop",   32'(out_alu_op), 32'd0);
    check("rst_rd",      32'(out_rd), 32'd0);
    check("rst_rdwe",    32'(out_rd_we), 32'd0);
    check("rst_imm",     out_imm, 32'd0);
    check("rst_illegal", 32'(out_illegal), 32'd0);
    check("rst_pc",      out_pc, 32'd0);
    rst = 1'b1;
    step();

    // ADDI x1,x0,5
    send(32'h100, 32'h0050_0093);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_class", 32'(out_class), 32'd1);
    check("addi_aluop", 32'(out_alu_op), 32'd0);
    check("addi_rd",    32'(out_rd), 32'd1);
    check("addi_rdwe",  32'(out_rd_we), 32'd1);
    check("addi_src1",  out_src1, 32'd0);
    check("addi_imm",   out_imm, 32'd5);
    check("addi_pc",    out_pc, 32'h100);
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // write x5 through the write port, then read it from the register file
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_DEAD;
    step();
    wb_we = 1'b0;
    send(32'h104, 32'h0012_8393);           // ADDI x7,x5,1
    check("rf_src1", out_src1, 32'h0000_DEAD);
    check("rf_imm",  out_imm, 32'd1);
    step();

    // ADD x6,x5,x5 with write-port bypass, then fwd port 1 overriding it
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_BEEF;
    send(32'h108, 32'h0052_8333);
    check("add_class", 32'(out_class), 32'd0);
    check("wb_src1",   out_src1, 32'h0000_BEEF);
    check("wb_src2",   out_src2, 32'h0000_BEEF);
    fwd_valid = 2'b10; fwd_rd = {5'd5, 5'd0}; fwd_data = {32'h77, 32'h0};
    #1;
    check("fwd_over_wb", out_src1, 32'h77);
    fwd_valid = '0; wb_we = 1'b0;
    step();

    // SRAI x2,x1,3 with both fwd ports matching x1
    fwd_valid = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_data = {32'h55, 32'hF0};
    send(32'h10C, 32'h4030_D113);
    check("srai_aluop", 32'(out_alu_op), 32'd7);
    check("srai_src1",  out_src1, 32'hF0);
    check("srai_imm",   out_imm, 32'd3);
    check("srai_rd",    32'(out_rd), 32'd2);
    fwd_valid = 2'b10;
    #1;
    check("fwd1_src1", out_src1, 32'h55);
    fwd_valid = 2'b00;
    #1;
    check("rf_x1_src1", out_src1, 32'd0);

    // back-to-back: BEQ x1,x2,-4 ; JAL x1,+2048 ; AUIPC x8,0x12345
    send(32'h110, 32'hFE20_8EE3);
    check("beq_class", 32'(out_class), 32'd4);
    check("beq_imm",   out_imm, 32'hFFFF_FFFC);
    check("beq_rdwe",  32'(out_rd_we), 32'd0);
    check("beq_f3",    32'(out_funct3), 32'd0);
    send(32'h114, 32'h0010_00EF);
    check("jal_valid", 32'(out_valid), 32'd1);
    check("jal_class", 32'(out_class), 32'd5);
    check("jal_imm",   out_imm, 32'h0000_0800);
    check("jal_rdwe",  32'(out_rd_we), 32'd1);
    send(32'h200, 32'h1234_5417);
    check("auipc_class", 32'(out_class), 32'd7);
    check("auipc_src1",  out_src1, 32'h200);
    check("auipc_imm",   out_imm, 32'h1234_5000);
    step();

    // LW x3,0(x0) then dependent ADD x4,x3,x3
    send(32'h300, 32'h0000_2183);
    check("lw_class", 32'(out_class), 32'd2);
    check("lw_rdwe",  32'(out_rd_we), 32'd1);
    in_valid = 1'b1; in_pc = 32'h304; in_inst = 32'h0031_8233;
    step();
    in_valid = 1'b0;
    #1;
    check("lu_class", 32'(out_class), 32'd0);
    check("lu_rd",    32'(out_rd), 32'd4);
`ifdef DEC_SCOREBOARD_EN
    check("lu_stall0_valid", 32'(out_valid), 32'd0);
    check("lu_stall0_ready", 32'(in_ready), 32'd0);
    step();
    check("lu_stall1_valid", 32'(out_valid), 32'd0);
    step();
    check("lu_issue_valid", 32'(out_valid), 32'd1);
`else
    check("lu_issue_valid", 32'(out_valid), 32'd1);
`endif
    step();

    // backpressure for 3 cycles with a competing packet offered, then flush
    out_ready = 1'b0;
    send(32'h400, 32'h0050_0093);
    in_valid = 1'b1; in_pc = 32'h404; in_inst = 32'h0012_8393;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_pc",    out_pc, 32'h400);
      check("bp_imm",   out_imm, 32'd5);
      step();
    end
    flush = 1'b1;
    #1;
    check("fl_ready", 32'(in_ready), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_discard", 32'(out_valid), 32'd0);
    check("fl_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // illegal: opcode 0x7F with rd=31, then OP with funct7=0x01
    send(32'h500, 32'h0000_0FFF);
    check("ill7f_illegal", 32'(out_illegal), 32'd1);
    check("ill7f_rdwe",    32'(out_rd_we), 32'd0);
    check("ill7f_valid",   32'(out_valid), 32'd1);
    send(32'h504, 32'h0220_82B3);
    check("illmul_illegal", 32'(out_illegal), 32'd1);
    check("illmul_rdwe",    32'(out_rd_we), 32'd0);
    check("illmul_rd",      32'(out_rd), 32'd5);
    step();

    // reset while a packet is held under backpressure
    out_ready = 1'b0;
    send(32'h600, 32'h0050_0093);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    step();
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    check("mrst_class", 32'(out_class), 32'd1);
    check("mrst_rd",    32'(out_rd), 32'd0);
    rst = 1'b1; out_ready = 1'b1;
    send(32'h604, 32'h0012_8393);           // x5 must read back as 0 after reset
    check("mrst_rf_src1", out_src1, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RV32I decode stage with valid/ready handshakes on both sides. It sits between fetch and execute. It holds one fetched instruction in an internal pipeline register and contains the 31×32 integer register file. It decodes the full RV32I base set: R, I, S, B, U and J formats, with immediate generation. Operands are resolved through a priority bypass network, and a per-register scoreboard enforces load-use interlocks.

## Interface
Parameters:
- FWD_PORTS, 2: number of bypass sources; index 0 has the highest priority.
- LOAD_LAT, 2: cycles after load issue during which its rd is unavailable (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch packet valid
- in_ready  out  1  decode can accept a packet
- in_pc  in  32  packet PC
- in_inst  in  32  packet instruction
- flush  in  1  kill held instruction (branch redirect)
- fwd_valid  in  FWD_PORTS  bypass source valid
- fwd_rd  in  5*FWD_PORTS  bypass destination register
- fwd_data  in  32*FWD_PORTS  bypass value
- wb_we, wb_rd, wb_data  in  1/5/32  register file write port
- out_valid  out  1  decoded packet valid
- out_ready  in  1  execute accepts packet
- out_pc  out  32  PC of held instruction
- out_class  out  3  0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 UPPER
- out_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- out_funct3  out  3  inst[14:12], passed through for branch and memory ops
- out_rd, out_rd_we  out  5/1  destination and write enable; rd_we=0 when rd==0, class STORE/BRANCH, or illegal
- out_src1, out_src2  out  32  resolved rs1/rs2 values; for UPPER, src1 = pc (AUIPC) or 0 (LUI)
- out_imm  out  32  sign-extended immediate for the decoded format
- out_illegal  out  1  unknown opcode/funct combination

## Operation
- Pipeline register:
  - hold_valid, hold_pc, hold_inst.
  - Load on in_valid && in_ready.
  - in_ready = !flush && (!hold_valid || out_fire), where out_fire = out_valid && out_ready.
- Decode is combinational from hold_inst.
  - OP-IMM: funct3=101 selects SRL/SRA by inst[30]; SUB is never produced.
  - OP: funct7 must be 0000000, or 0100000 for ADD/SUB and SRL/SRA; otherwise illegal.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All of the above are sign-extended to 32 bits.
  - U: {inst[31:12], 12'b0}.
- Operand priority for each of rs1 and rs2:
  1. index 0: value is 0.
  2. lowest-index fwd port with fwd_valid && fwd_rd match.
  3. wb_we && wb_rd match: wb_data.
  4. register file.
- Register file writes at posedge when wb_we && wb_rd != 0; x0 is never written.
- Scoreboard (macro-controlled, see Configuration):
  - pending[r] is a 3-bit down-counter.
  - On out_fire of a LOAD with rd != 0: pending[rd] <= LOAD_LAT. This reload also applies if already pending.
  - Otherwise, nonzero counters decrement each cycle.
  - hazard = (rs1 used && pending[rs1] != 0) || (rs2 used && pending[rs2] != 0). R/S/B formats use rs1 and rs2; I format uses rs1; U/J use neither.
- out_valid = hold_valid && !hazard && !flush.
- Flush:
  - hold_valid <= 0 at the next edge; no packet is accepted that cycle.
  - Scoreboard counters are not cleared, because loads already issued remain in flight.
- Illegal instructions still issue, with out_illegal=1 and out_rd_we=0.

## Timing
- Reset state:
  - hold_valid=0, hold_inst=32'h00000013 (NOP), hold_pc=0, all registers 0, all counters 0.
  - Outputs: out_valid=0, in_ready=1, out_class=1, out_alu_op=0, out_rd=0, out_rd_we=0, out_imm=0, out_illegal=0.
- Latency: a packet accepted at edge N is presented at out_* during cycle N+1 if there is no hazard.
- Back-to-back: one instruction per cycle when out_ready=1 and there are no hazards.
- Backpressure: while out_valid && !out_ready, all out_* are held stable.
- Hazard stall: the packet stays held, out_valid=0, in_ready=0.
- Load-use: a load issuing at edge N followed by a dependent instruction stalls the dependent instruction LOAD_LAT cycles, i.e. it issues at edge N+LOAD_LAT+1.
- flush and in_valid in the same cycle: flush wins and the incoming packet is dropped.
- rst mid-stall: everything returns to the reset state at the next edge.

## Configuration
- DEC_SCOREBOARD_EN defined: scoreboard and load-use interlock are present as described.
- DEC_SCOREBOARD_EN undefined:
  - No counters; hazard is tied to 0, so out_valid = hold_valid && !flush.
  - Load-use scheduling is the compiler's responsibility.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) -> next cycle out_valid=1, class=1, alu_op=0, rd=1, rd_we=1, src1=0, imm=5.
- SRAI x2,x1,3 (0x4030D113) with fwd port 0 valid, rd=1, data=0xF0 -> alu_op=7, src1=0xF0, imm=3. Port 1 also matching with another value -> port 0 still wins.
- BEQ with imm=-4, then JAL with imm=+2048 -> out_imm = 0xFFFFFFFC and 0x00000800; rd_we=0 for the BEQ.
- LW x3 then ADD x4,x3,x3, LOAD_LAT=2 -> ADD withheld 2 cycles then issues; with DEC_SCOREBOARD_EN undefined it issues immediately.
- out_ready=0 for 3 cycles -> outputs stable and in_ready=0; flush during the hold -> out_valid=0 next cycle and the held packet is discarded.
- Opcode 0x7F, or OP with funct7=0x01 -> out_illegal=1, out_rd_we=0.
